// File: rtl/chunk_serial_adder.sv
// chunk_serial_adder
//   Multi-cycle adder/subtractor that processes CHUNK bits per clock, least
//   significant chunk first, taking N = WIDTH/CHUNK RUN cycles per operation.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      begin one operation (sampled only in IDLE)
//   din1, din2 operands (WIDTH bits)
//   cin        carry-in, used only when sub=0
//   sub        0: din1+din2+cin   1: din1-din2 (din1 + ~din2 + 1)
//   busy       high while in RUN
//   done       one-cycle pulse: sum/cout/ovf just updated
//   sum        low WIDTH bits of the result
//   cout       carry out of bit WIDTH-1 (in sub mode 1 = no borrow)
//   ovf        two's-complement signed overflow
//   dbg_state  current FSM state (IDLE=0, RUN=1, DONE=2) for observation
//
// Handshake: start is a request, not a valid/ready pair. It is honoured only
// on an edge where the FSM is IDLE; a start seen in RUN or DONE is dropped,
// never queued. done is a single-cycle pulse and needs no acknowledgement.
module chunk_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int N  = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("chunk_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Latched operands: b_q already holds ~din2 in subtract mode, and the
  // initial running carry holds the effective carry-in.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] part_q;   // partial sums of chunks already processed
  logic             carry_q;  // running carry between chunks
  logic [KW-1:0]    k_q;      // index of the chunk processed this cycle

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_co;
  logic             carry_msb;
  logic             last_chunk;
  logic [WIDTH-1:0] full_sum;
  int               base;

  // ---------------- chunk datapath ----------------
  always_comb begin
    base       = int'(k_q) * CHUNK;
    chunk_a    = a_q[base +: CHUNK];
    chunk_b    = b_q[base +: CHUNK];
    {chunk_co, chunk_s} = {1'b0, chunk_a} + {1'b0, chunk_b} +
                          {{CHUNK{1'b0}}, carry_q};
    // Partial sum with this cycle's chunk merged in; on the last chunk this
    // is the complete result.
    full_sum   = part_q;
    full_sum[base +: CHUNK] = chunk_s;
    // Carry into the top bit recovered from the top-bit sum equation.
    carry_msb  = chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1] ^ chunk_s[CHUNK-1];
    last_chunk = (k_q == KW'(N - 1));
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= din1;
            b_q     <= sub ? ~din2 : din2;
            carry_q <= sub ? 1'b1 : cin;
            part_q  <= '0;
            k_q     <= '0;
          end
        end
        RUN: begin
          part_q  <= full_sum;
          carry_q <= chunk_co;
          if (last_chunk) begin
            k_q  <= '0;
            sum  <= full_sum;
            cout <= chunk_co;
            ovf  <= carry_msb ^ chunk_co;
          end else begin
            k_q  <= k_q + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// tb_chunk_serial_adder
//   Bench for chunk_serial_adder with two builds: WIDTH=16/CHUNK=4 (N=4) and
//   WIDTH=16/CHUNK=16 (N=1). Expected results come from a whole-word
//   arithmetic model; expected timing comes from the cycle counts N and N+1.
module tb_chunk_serial_adder;

  localparam int W  = 16;
  localparam int N1 = 4;
  localparam int N2 = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start, start2;
  logic [W-1:0] din1, din2;
  logic         cin, sub;

  logic         busy1, done1, cout1, ovf1;
  logic [W-1:0] sum1;
  logic [1:0]   dbg1;
  logic         busy2, done2, cout2, ovf2;
  logic [W-1:0] sum2;
  logic [1:0]   dbg2;

  chunk_serial_adder #(.WIDTH(W), .CHUNK(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .din1(din1), .din2(din2),
    .cin(cin), .sub(sub), .busy(busy1), .done(done1), .sum(sum1),
    .cout(cout1), .ovf(ovf1), .dbg_state(dbg1)
  );

  chunk_serial_adder #(.WIDTH(W), .CHUNK(16)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .din1(din1), .din2(din2),
    .cin(cin), .sub(sub), .busy(busy2), .done(done2), .sum(sum2),
    .cout(cout2), .ovf(ovf2), .dbg_state(dbg2)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [W+1:0] exp_q[$];        // {ovf, cout, sum}
  logic [W+1:0] held1, held2;    // last published result of each build

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Whole-word reference: subtraction is a + ~b + 1, overflow is the
  // classic same-sign-in / different-sign-out rule.
  function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic c, input logic s);
    logic [W-1:0] be;
    logic         ci;
    logic [W:0]   t;
    logic         ov;
    be = s ? ~b : b;
    ci = s ? 1'b1 : c;
    t  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ci};
    ov = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
    return {ov, t[W], t[W-1:0]};
  endfunction

  task automatic sample(input bit which, output logic b, output logic d,
                        output logic [W+1:0] r);
    if (which) begin b = busy2; d = done2; r = {ovf2, cout2, sum2}; end
    else       begin b = busy1; d = done1; r = {ovf1, cout1, sum1}; end
  endtask

  task automatic pop_exp(output logic [W+1:0] e);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL exp_q_empty got=0 exp=1");
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic scramble_inputs();
    din1 = W'($urandom); din2 = W'($urandom);
    cin  = 1'($urandom); sub  = 1'($urandom);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge where the selected build will be IDLE at the next
  // edge; returns at a negedge with that build back in IDLE.
  task automatic run_op(input bit which, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c, input logic s);
    int nc;
    logic bo, dn;
    logic [W+1:0] r, e;
    nc = which ? N2 : N1;
    exp_q.push_back(model(a, b, c, s));
    din1 = a; din2 = b; cin = c; sub = s;
    if (which) start2 = 1'b1; else start = 1'b1;
    for (int n = 1; n <= nc + 2; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0; start2 = 1'b0;
        scramble_inputs();   // operand changes in RUN must not matter
      end
      sample(which, bo, dn, r);
      check("busy", 32'(bo), 32'(n <= nc));
      check("done", 32'(dn), 32'(n == nc + 1));
      if (n == nc + 1) begin
        pop_exp(e);
        check("result", 32'(r), 32'(e));
        if (which) held2 = e; else held1 = e;
      end else begin
        check("hold", 32'(r), 32'(which ? held2 : held1));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_busy1", 32'(busy1), 0);
    check("rst_done1", 32'(done1), 0);
    check("rst_res1", 32'({ovf1, cout1, sum1}), 0);
    check("rst_busy2", 32'(busy2), 0);
    check("rst_done2", 32'(done2), 0);
    check("rst_res2", 32'({ovf2, cout2, sum2}), 0);
    held1 = '0; held2 = '0;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W+1:0] e;
    din1 = '0; din2 = '0; cin = 1'b0; sub = 1'b0;
    start = 1'b0; start2 = 1'b0; rst = 1'b1;
    held1 = '0; held2 = '0;
    @(negedge clk);
    do_reset();

    // Directed cases; the first is started in the first cycle out of reset.
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);  // 0000 c1 v0
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);  // 8000 c0 v1
    run_op(0, 16'h1234, 16'h0FFF, 1'b1, 1'b0);  // 2234 c0 v0
    run_op(0, 16'h0005, 16'h0007, 1'b1, 1'b1);  // FFFE c0 v0
    run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1);  // 7FFF c1 v1
    run_op(1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);  // FFFF c1 v0, N=1

    // Start pulsed with new operands in RUN and again in DONE: ignored.
    exp_q.push_back(model(16'h4321, 16'h1111, 1'b0, 1'b0));
    din1 = 16'h4321; din2 = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      logic bo, dn;
      logic [W+1:0] r;
      @(negedge clk);
      sample(0, bo, dn, r);
      check("ign_busy", 32'(bo), 32'(n <= N1));
      check("ign_done", 32'(dn), 32'(n == N1 + 1));
      if (n == N1 + 1) begin
        pop_exp(e);
        check("ign_result", 32'(r), 32'(e));
        held1 = e;
      end
      start = (n == 2) || (n == N1 + 1);
      if (n == 2) scramble_inputs();
    end

    // Start held high: second accept in the IDLE cycle after DONE.
    exp_q.push_back(model(16'hA5A5, 16'h5A5B, 1'b0, 1'b0));
    exp_q.push_back(model(16'h0100, 16'h0200, 1'b0, 1'b1));
    din1 = 16'hA5A5; din2 = 16'h5A5B; cin = 1'b0; sub = 1'b0; start = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      logic bo, dn;
      logic [W+1:0] r;
      @(negedge clk);
      sample(0, bo, dn, r);
      check("held_busy", 32'(bo), 32'((n <= 4) || (n >= 7 && n <= 10)));
      check("held_done", 32'(dn), 32'((n == 5) || (n == 11)));
      if (n == 5 || n == 11) begin
        pop_exp(e);
        check("held_result", 32'(r), 32'(e));
        held1 = e;
      end else begin
        check("held_hold", 32'(r), 32'(held1));
      end
      if (n == 5) begin din1 = 16'h0100; din2 = 16'h0200; sub = 1'b1; end
      if (n == 7) start = 1'b0;
    end

    // Reset in RUN cycle 2 aborts with no done and clears the result.
    run_op(0, 16'h1234, 16'h0001, 1'b0, 1'b0);
    din1 = 16'h2222; din2 = 16'h3333; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("abort_busy_pre", 32'(busy1), 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy1), 0);
    check("abort_done", 32'(done1), 0);
    check("abort_res", 32'({ovf1, cout1, sum1}), 0);
    check("abort_res2", 32'({ovf2, cout2, sum2}), 0);
    held1 = '0; held2 = '0;
    rst = 1'b0;
    run_op(0, 16'hABCD, 16'h1234, 1'b1, 1'b0);  // fresh start right after reset

    // Randomized operations on both builds.
    for (int i = 0; i < 24; i++)
      run_op(0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 8; i++)
      run_op(1, W'($urandom), W'($urandom), 1'($urandom),
             1'($urandom_range(0, 1)));

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL exp_q_left got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
